// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: icache request/response, backend redirect and decode handshake.
// master = fetch_ctrl side, slave = icache/backend/decode side.
interface fetch_ctrl_if;
    logic         ic_req;
    logic [31:0]  ic_pc;
    logic         ic_ready;
    logic         ic_resp_valid;
    logic [127:0] ic_resp_inst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         dec_valid;
    logic         dec_ready;
    logic [31:0]  dec_pc;
    logic [127:0] dec_inst;
    logic [3:0]   dec_mask;

    modport master (
        output ic_req, ic_pc, dec_valid, dec_pc, dec_inst, dec_mask,
        input  ic_ready, ic_resp_valid, ic_resp_inst, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  ic_req, ic_pc, dec_valid, dec_pc, dec_inst, dec_mask,
        output ic_ready, ic_resp_valid, ic_resp_inst, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding 4-wide icache fetch, packs responses into decode groups.
// Latency: icache response at t -> dec_valid at t+1; redirect at t -> new ic_pc at t+1 (or after stale drop).
// Backpressure: output register plus one-entry skid; fetching pauses while skid is full. FETCH_ALIGN_EN: 16B-aligned groups.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  fi
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [127:0] inst;
        logic [3:0]   mask;
    } grp_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        out_valid_q, out_valid_d;
    grp_t        out_q, out_d;
    logic        skid_valid_q, skid_valid_d;
    grp_t        skid_q, skid_d;

    grp_t        resp_grp;
    logic [31:0] req_pc;
    logic [31:0] next_pc;
    logic        out_free;

`ifdef FETCH_ALIGN_EN
    logic [3:0]  align_mask;

    always_comb begin
        req_pc     = fetch_pc_q & 32'hFFFF_FFF0;
        align_mask = 4'b1111 << fetch_pc_q[3:2];
        next_pc    = req_pc + 32'd16;
        resp_grp   = '0;
        resp_grp.pc   = req_pc;
        resp_grp.mask = align_mask;
        // Slots before the entry PC belong to the previous block and are zeroed.
        for (int i = 0; i < 4; i++) begin
            resp_grp.inst[32*i +: 32] = align_mask[i] ? fi.ic_resp_inst[32*i +: 32] : 32'h0;
        end
    end
`else
    always_comb begin
        req_pc        = fetch_pc_q;
        next_pc       = fetch_pc_q + 32'd16;
        resp_grp      = '0;
        resp_grp.pc   = fetch_pc_q;
        resp_grp.inst = fi.ic_resp_inst;
        resp_grp.mask = 4'b1111;
    end
`endif

    assign out_free = !out_valid_q || fi.dec_ready;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (out_valid_q && fi.dec_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (fi.ic_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fi.ic_resp_valid) begin
                    fetch_pc_d = next_pc;
                    if (out_free) begin
                        out_d       = resp_grp;
                        out_valid_d = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        skid_d       = resp_grp;
                        skid_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (fi.ic_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over everything; an old request still in flight must be drained first.
        if (fi.redirect_valid) begin
            fetch_pc_d   = fi.redirect_pc & 32'hFFFF_FFFC;
            out_valid_d  = 1'b0;
            out_d        = out_q;
            skid_valid_d = 1'b0;
            skid_d       = skid_q;
            if ((state_q == S_WAIT && !fi.ic_resp_valid) ||
                (state_q == S_REQ && fi.ic_ready) ||
                (state_q == S_DROP && !fi.ic_resp_valid)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign fi.ic_req    = rst_n && (state_q == S_REQ);
    assign fi.ic_pc     = req_pc;
    assign fi.dec_valid = out_valid_q;
    assign fi.dec_pc    = out_q.pc;
    assign fi.dec_inst  = out_q.inst;
    assign fi.dec_mask  = out_q.mask;

endmodule
